// File: rtl/readout_capture_buffer.sv
// Ping-pong capture buffer for an indexed cell-data stream.
// One bank fills while the reader scans the other; banks swap when an acquisition ends.
module readout_capture_buffer #(
  parameter int READOUT_WIDTH = 9,
  parameter int DATA_WIDTH    = 32,
  parameter int TIMEOUT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     acqStart,
  input  logic [TIMEOUT_WIDTH-1:0] acqTimeout,
  input  logic [READOUT_WIDTH:0]   expectedCount,
  input  logic [READOUT_WIDTH-1:0] inIndex,
  input  logic [DATA_WIDTH-1:0]    inData,
  input  logic                     inValid,
  output logic                     readoutActive,
  output logic                     readoutValid,
  input  logic [READOUT_WIDTH-1:0] readoutAddress,
  output logic                     readoutPresent,
  output logic [DATA_WIDTH-1:0]    readoutData,
  output logic [READOUT_WIDTH:0]   receivedCount,
  output logic [15:0]              dupCount,
  output logic [15:0]              droppedCount,
  output logic                     timedOut
);

  localparam int DEPTH = 1 << READOUT_WIDTH;
  localparam int CW    = READOUT_WIDTH + 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_ACQ  = 1'b1;

  localparam logic [TIMEOUT_WIDTH-1:0] T_ONE = 1;
  localparam logic [CW-1:0]            C_ONE = 1;
  localparam logic [15:0]              S_ONE = 16'd1;

  logic [0:0]               state;
  logic                     read_bank;
  logic                     write_bank;
  logic [1:0][DEPTH-1:0]    present;
  logic [TIMEOUT_WIDTH-1:0] timer;

  logic [DATA_WIDTH-1:0] mem0 [DEPTH];
  logic [DATA_WIDTH-1:0] mem1 [DEPTH];

  logic          in_acq;
  logic          wr;
  logic          hit;
  logic          is_new;
  logic          is_dup;
  logic          drop;
  logic          done;
  logic          tmo;
  logic [CW-1:0] recv_next;

  assign write_bank = ~read_bank;
  assign in_acq     = (state == ST_ACQ);

  always_comb begin
    wr     = in_acq & ~acqStart & inValid;
    hit    = present[write_bank][inIndex];
    is_new = wr & ~hit;
    is_dup = wr & hit;
    drop   = inValid & (~in_acq | acqStart);
    recv_next = receivedCount;
    if (is_new && receivedCount != '1)
      recv_next = receivedCount + C_ONE;
    // completion counts this cycle's write, and beats a same-cycle timeout
    done = in_acq & ~acqStart & (recv_next == expectedCount);
    tmo  = in_acq & ~acqStart & ~done
         & (acqTimeout != '0)
         & (timer == acqTimeout - T_ONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= ST_IDLE;
      read_bank     <= 1'b0;
      present       <= '0;
      timer         <= '0;
      readoutValid  <= 1'b0;
      timedOut      <= 1'b0;
      receivedCount <= '0;
      dupCount      <= '0;
      droppedCount  <= '0;
    end else if (acqStart) begin
      state                <= ST_ACQ;
      present[write_bank]  <= '0;
      timer                <= '0;
      readoutValid         <= 1'b0;
      timedOut             <= 1'b0;
      receivedCount        <= '0;
      dupCount             <= '0;
      droppedCount         <= inValid ? S_ONE : '0;
    end else begin
      if (drop && droppedCount != '1)
        droppedCount <= droppedCount + S_ONE;
      if (in_acq) begin
        if (timer != '1)
          timer <= timer + T_ONE;
        receivedCount <= recv_next;
        if (is_new)
          present[write_bank][inIndex] <= 1'b1;
        if (is_dup && dupCount != '1)
          dupCount <= dupCount + S_ONE;
        if (done || tmo) begin
          state     <= ST_IDLE;
          read_bank <= ~read_bank;
        end
        if (done)
          readoutValid <= 1'b1;
        if (tmo)
          timedOut <= 1'b1;
      end
    end
  end

  // data words are not reset; the present bits qualify them
  always_ff @(posedge clk) begin
    if (wr) begin
      if (write_bank)
        mem1[inIndex] <= inData;
      else
        mem0[inIndex] <= inData;
    end
  end

  assign readoutActive  = in_acq;
  assign readoutPresent = present[read_bank][readoutAddress];
  assign readoutData    = read_bank ? mem1[readoutAddress]
                                    : mem0[readoutAddress];

endmodule

// File: tb/tb_readout_capture_buffer.sv
// Bench for readout_capture_buffer: directed acquisitions,
// end-of-acquisition scoreboard and read-bank scans.
module tb_readout_capture_buffer;

  localparam int RW = 9;
  localparam int DW = 32;
  localparam int TW = 16;
  localparam int DEPTH = 1 << RW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          acqStart;
  logic [TW-1:0] acqTimeout;
  logic [RW:0]   expectedCount;
  logic [RW-1:0] inIndex;
  logic [DW-1:0] inData;
  logic          inValid;
  logic          readoutActive;
  logic          readoutValid;
  logic [RW-1:0] readoutAddress;
  logic          readoutPresent;
  logic [DW-1:0] readoutData;
  logic [RW:0]   receivedCount;
  logic [15:0]   dupCount;
  logic [15:0]   droppedCount;
  logic          timedOut;

  readout_capture_buffer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .acqStart      (acqStart),
    .acqTimeout    (acqTimeout),
    .expectedCount (expectedCount),
    .inIndex       (inIndex),
    .inData        (inData),
    .inValid       (inValid),
    .readoutActive (readoutActive),
    .readoutValid  (readoutValid),
    .readoutAddress(readoutAddress),
    .readoutPresent(readoutPresent),
    .readoutData   (readoutData),
    .receivedCount (receivedCount),
    .dupCount      (dupCount),
    .droppedCount  (droppedCount),
    .timedOut      (timedOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic        to;
    logic [RW:0] recv;
    logic [15:0] dup;
  } ev_t;

  ev_t sb[$];

  int n_chk  = 0;
  int n_fail = 0;

  bit          mp [DEPTH];
  logic [DW-1:0] md [DEPTH];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [RW:0] e, input logic [TW-1:0] t);
    expectedCount = e;
    acqTimeout = t;
    acqStart = 1'b1;
    tick();
    acqStart = 1'b0;
  endtask

  task automatic send(input int idx, input logic [DW-1:0] d);
    inIndex = RW'(idx);
    inData = d;
    inValid = 1'b1;
    tick();
    inValid = 1'b0;
  endtask

  task automatic push(input logic v, input logic to,
                      input int recv, input int dup);
    ev_t e;
    e.valid = v;
    e.to = to;
    e.recv = (RW + 1)'(recv);
    e.dup = 16'(dup);
    sb.push_back(e);
  endtask

  task automatic model_clear();
    for (int a = 0; a < DEPTH; a++) mp[a] = 1'b0;
  endtask

  task automatic model_add(input int idx, input logic [DW-1:0] d);
    mp[idx] = 1'b1;
    md[idx] = d;
  endtask

  task automatic check_bank(input string tag);
    int errs;
    errs = 0;
    for (int a = 0; a < DEPTH; a++) begin
      readoutAddress = RW'(a);
      #1;
      if (readoutPresent !== mp[a])
        errs++;
      else if (mp[a] && readoutData !== md[a])
        errs++;
    end
    chk({"bank_", tag}, 64'(errs), 64'd0);
  endtask

  // scoreboard monitor: one expected event per readoutActive fall
  logic prev_active = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_active = 1'b0;
    end else begin
      if (prev_active && !readoutActive) begin
        if (sb.size() == 0) begin
          chk("unexpected_end", 64'd1, 64'd0);
        end else begin
          ev_t e;
          e = sb.pop_front();
          chk("end_event",
              64'({readoutValid, timedOut, receivedCount, dupCount}),
              64'({e.valid, e.to, e.recv, e.dup}));
        end
      end
      prev_active = readoutActive;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    rst_n = 1'b0;
    acqStart = 1'b0;
    acqTimeout = '0;
    expectedCount = '0;
    inIndex = '0;
    inData = '0;
    inValid = 1'b0;
    readoutAddress = '0;
    model_clear();
    repeat (3) tick();

    chk("reset_outputs",
        64'({readoutActive, readoutValid, timedOut,
             receivedCount, dupCount, droppedCount}),
        64'd0);
    check_bank("reset");
    rst_n = 1'b1;
    tick();

    // normal completion
    push(1'b1, 1'b0, 4, 0);
    start(4, 0);
    for (int i = 0; i < 4; i++) send(i, 32'h1111_0000 + i);
    chk("A_valid_active", 64'({readoutValid, readoutActive}), 64'b10);
    chk("A_recv", 64'(receivedCount), 64'd4);
    model_clear();
    for (int i = 0; i < 4; i++) model_add(i, 32'h1111_0000 + i);
    check_bank("A");

    // duplicate then timeout
    push(1'b0, 1'b1, 2, 1);
    start(4, 20);
    send(5, 32'h0000_0055);
    send(5, 32'h0000_005A);
    send(6, 32'h0000_0066);
    cnt = 3;
    while (readoutActive && cnt < 40) begin
      tick();
      cnt++;
    end
    chk("timeout_cycles", 64'(cnt), 64'd20);
    chk("timeout_flags",
        64'({timedOut, readoutValid, readoutActive}), 64'b100);
    chk("timeout_dup", 64'(dupCount), 64'd1);
    model_clear();
    model_add(5, 32'h0000_005A);
    model_add(6, 32'h0000_0066);
    check_bank("timeout");

    // back-to-back A then B, reader scans during B
    push(1'b1, 1'b0, 2, 0);
    start(2, 0);
    send(10, 32'hAAAA_0010);
    send(11, 32'hAAAA_0011);
    model_clear();
    model_add(10, 32'hAAAA_0010);
    model_add(11, 32'hAAAA_0011);
    check_bank("bb_A");
    push(1'b1, 1'b0, 3, 0);
    start(3, 0);
    chk("bb_B_valid_low", 64'(readoutValid), 64'd0);
    send(20, 32'hBBBB_0020);
    check_bank("bb_during_B1");
    send(21, 32'hBBBB_0021);
    check_bank("bb_during_B2");
    send(22, 32'hBBBB_0022);
    model_clear();
    model_add(20, 32'hBBBB_0020);
    model_add(21, 32'hBBBB_0021);
    model_add(22, 32'hBBBB_0022);
    check_bank("bb_B");

    // restart on the third acquisition cycle, with a dropped entry
    start(4, 0);
    send(30, 32'hCCCC_0030);
    send(31, 32'hCCCC_0031);
    chk("restart_pre_recv", 64'(receivedCount), 64'd2);
    push(1'b1, 1'b0, 1, 0);
    expectedCount = 1;
    inIndex = RW'(40);
    inData = 32'hDEAD_0040;
    inValid = 1'b1;
    acqStart = 1'b1;
    tick();
    acqStart = 1'b0;
    inValid = 1'b0;
    chk("restart_counts",
        64'({receivedCount, droppedCount, readoutActive}),
        64'({10'd0, 16'd1, 1'b1}));
    check_bank("restart_old");
    send(41, 32'hCCCC_0041);
    model_clear();
    model_add(41, 32'hCCCC_0041);
    check_bank("restart_done");

    // idle drops: one carried from the restart cycle plus three here
    send(50, 32'hEEEE_0050);
    send(51, 32'hEEEE_0051);
    send(52, 32'hEEEE_0052);
    chk("dropped", 64'(droppedCount), 64'd4);
    chk("dropped_recv", 64'(receivedCount), 64'd1);
    check_bank("dropped");

    // expectedCount zero: empty bank swapped after one cycle
    push(1'b1, 1'b0, 0, 0);
    start(0, 0);
    chk("zero_active", 64'(readoutActive), 64'd1);
    tick();
    chk("zero_end", 64'({readoutActive, readoutValid}), 64'b01);
    model_clear();
    check_bank("zero");

    // completion and timeout on the same cycle
    push(1'b1, 1'b0, 1, 0);
    start(1, 2);
    tick();
    send(60, 32'h6060_6060);
    chk("tie_flags", 64'({readoutValid, timedOut}), 64'b10);
    model_add(60, 32'h6060_6060);
    check_bank("tie");

    // reset mid-acquisition
    start(4, 0);
    send(70, 32'h7070_7070);
    chk("mid_recv", 64'(receivedCount), 64'd1);
    rst_n = 1'b0;
    tick();
    chk("mid_reset_outputs",
        64'({readoutActive, readoutValid, timedOut,
             receivedCount, dupCount, droppedCount}),
        64'd0);
    model_clear();
    check_bank("mid_reset");
    rst_n = 1'b1;
    tick();

    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
